// File: rtl/constraint_scheduler.sv
// constraint_scheduler
// Sequencer around the combinational enforce_constraint datapath of the
// rope/chain simulator. Holds a register file of point positions and runs
// ITERS Gauss-Seidel sweeps over points 1..N_POINTS-1 on each start. Point 0
// is the anchor and is never written by a run.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   ld_valid/ld_idx/ld_x/ld_y     file write port, accepted while ld_ready
//   ld_ready                      high while idle (not busy)
//   start                         begin a run, sampled in IDLE only
//   busy, done, iter_cnt          run status, done is a one-cycle pulse
//   rd_idx, rd_x, rd_y            combinational file read, 0 when out of range
//   ec_up_*/ec_*/ec_down_*        registered datapath operands
//   ec_is_last                    operands belong to the last point
//   ec_x_new, ec_y_new            datapath result, written back in WRITE
//
// state | meaning
// IDLE  | waiting for start, loads allowed
// SETUP | register neighbour operands for point idx
// EVAL  | settle cycle for the combinational datapath
// WRITE | store result into file[idx], advance idx / sweep
// DONE  | done pulse, back to IDLE next edge

module constraint_scheduler #(
    parameter int N_POINTS = 16,
    parameter int ITERS    = 4,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [IDX_W-1:0] ld_idx,
    input  logic [31:0]      ld_x,
    input  logic [31:0]      ld_y,
    output logic             ld_ready,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] iter_cnt,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_x,
    output logic [31:0]      rd_y,
    output logic [31:0]      ec_up_x,
    output logic [31:0]      ec_up_y,
    output logic [31:0]      ec_x,
    output logic [31:0]      ec_y,
    output logic [31:0]      ec_down_x,
    output logic [31:0]      ec_down_y,
    output logic             ec_is_last,
    input  logic [31:0]      ec_x_new,
    input  logic [31:0]      ec_y_new
);

    localparam logic [IDX_W:0]   NUM_PTS   = (IDX_W+1)'(N_POINTS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_POINTS - 1);
    localparam logic [IDX_W-1:0] LAST_ITER = IDX_W'(ITERS - 1);
    localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EVAL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_up;
    logic [IDX_W-1:0] idx_down;
    logic             ld_hit;
    logic [31:0]      file_x [N_POINTS];
    logic [31:0]      file_y [N_POINTS];

    // The last point has no lower neighbour; it mirrors its upper one instead.
    assign idx_up   = idx - ONE;
    assign idx_down = (idx == LAST_IDX) ? idx - ONE : idx + ONE;

    assign ld_ready = !busy;
    assign ld_hit   = ld_valid && !busy && ({1'b0, ld_idx} < NUM_PTS);

    always_comb begin
        rd_x = '0;
        rd_y = '0;
        if ({1'b0, rd_idx} < NUM_PTS) begin
            rd_x = file_x[rd_idx];
            rd_y = file_y[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= ONE;
            iter_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ec_up_x    <= '0;
            ec_up_y    <= '0;
            ec_x       <= '0;
            ec_y       <= '0;
            ec_down_x  <= '0;
            ec_down_y  <= '0;
            ec_is_last <= 1'b0;
            for (int i = 0; i < N_POINTS; i++) begin
                file_x[i] <= '0;
                file_y[i] <= '0;
            end
        end else begin
            // Loads only happen while idle, so they never collide with WRITE.
            if (ld_hit) begin
                file_x[ld_idx] <= ld_x;
                file_y[ld_idx] <= ld_y;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_SETUP;
                        idx      <= ONE;
                        iter_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_SETUP: begin
                    ec_up_x    <= file_x[idx_up];
                    ec_up_y    <= file_y[idx_up];
                    ec_x       <= file_x[idx];
                    ec_y       <= file_y[idx];
                    ec_down_x  <= file_x[idx_down];
                    ec_down_y  <= file_y[idx_down];
                    ec_is_last <= (idx == LAST_IDX);
                    state      <= S_EVAL;
                end
                S_EVAL: begin
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    file_x[idx] <= ec_x_new;
                    file_y[idx] <= ec_y_new;
                    if (idx < LAST_IDX) begin
                        idx   <= idx + ONE;
                        state <= S_SETUP;
                    end else if (iter_cnt < LAST_ITER) begin
                        iter_cnt <= iter_cnt + ONE;
                        idx      <= ONE;
                        state    <= S_SETUP;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_constraint_scheduler.sv
// Bench for constraint_scheduler. Two instances (N_POINTS=4): instance 0 runs
// ITERS=2, instance 1 runs ITERS=1. A reference model describes a run as a
// numbered list of 3-cycle steps and is compared with both instances on
// every falling edge; directed checks pin hand-computed values.

module tb_constraint_scheduler;

    localparam int NP   = 4;
    localparam int STEP = 3 * (NP - 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        ld_valid   [2];
    logic [1:0]  ld_idx     [2];
    logic [31:0] ld_x       [2];
    logic [31:0] ld_y       [2];
    logic        ld_ready   [2];
    logic        start      [2];
    logic        busy       [2];
    logic        done       [2];
    logic [1:0]  iter_cnt   [2];
    logic [1:0]  rd_idx     [2];
    logic [31:0] rd_x       [2];
    logic [31:0] rd_y       [2];
    logic [31:0] ec_up_x    [2];
    logic [31:0] ec_up_y    [2];
    logic [31:0] ec_x       [2];
    logic [31:0] ec_y       [2];
    logic [31:0] ec_down_x  [2];
    logic [31:0] ec_down_y  [2];
    logic        ec_is_last [2];
    logic [31:0] ec_x_new   [2];
    logic [31:0] ec_y_new   [2];
    logic        stub_up    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        constraint_scheduler #(
            .N_POINTS(NP),
            .ITERS   ((g == 0) ? 2 : 1),
            .IDX_W   (2)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .ld_valid  (ld_valid[g]),
            .ld_idx    (ld_idx[g]),
            .ld_x      (ld_x[g]),
            .ld_y      (ld_y[g]),
            .ld_ready  (ld_ready[g]),
            .start     (start[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .iter_cnt  (iter_cnt[g]),
            .rd_idx    (rd_idx[g]),
            .rd_x      (rd_x[g]),
            .rd_y      (rd_y[g]),
            .ec_up_x   (ec_up_x[g]),
            .ec_up_y   (ec_up_y[g]),
            .ec_x      (ec_x[g]),
            .ec_y      (ec_y[g]),
            .ec_down_x (ec_down_x[g]),
            .ec_down_y (ec_down_y[g]),
            .ec_is_last(ec_is_last[g]),
            .ec_x_new  (ec_x_new[g]),
            .ec_y_new  (ec_y_new[g])
        );
        // Stub datapath: either "x + 1.0" or "copy the up neighbour".
        assign ec_x_new[g] = stub_up[g] ? ec_up_x[g] : ec_x[g] + 32'h0001_0000;
        assign ec_y_new[g] = stub_up[g] ? ec_up_y[g] : ec_y[g];
    end

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_x    [2][NP];
    logic [31:0] m_y    [2][NP];
    logic [31:0] m_ops  [2][6];   // up_x, up_y, x, y, down_x, down_y
    logic        m_last [2];
    logic        m_busy [2];
    logic        m_done [2];
    int          m_c    [2];      // edges since the accepting edge
    int          m_iter [2];

    function automatic int iters_of(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    task automatic model_step(input int g);
        int k, p, ph;
        if (!m_busy[g]) begin
            if (ld_valid[g] && int'(ld_idx[g]) < NP) begin
                m_x[g][ld_idx[g]] = ld_x[g];
                m_y[g][ld_idx[g]] = ld_y[g];
            end
            if (start[g]) begin
                m_busy[g] = 1'b1;
                m_c[g]    = 0;
                m_iter[g] = 0;
            end
        end else if (m_done[g]) begin
            m_done[g] = 1'b0;
            m_busy[g] = 1'b0;
        end else begin
            m_c[g]++;
            k  = (m_c[g] - 1) / 3;
            ph = (m_c[g] - 1) % 3;
            p  = 1 + k % (NP - 1);
            if (ph == 0) begin
                m_ops[g][0] = m_x[g][p-1];
                m_ops[g][1] = m_y[g][p-1];
                m_ops[g][2] = m_x[g][p];
                m_ops[g][3] = m_y[g][p];
                m_ops[g][4] = (p == NP-1) ? m_x[g][p-1] : m_x[g][p+1];
                m_ops[g][5] = (p == NP-1) ? m_y[g][p-1] : m_y[g][p+1];
                m_last[g]   = (p == NP-1);
            end else if (ph == 2) begin
                if (stub_up[g]) begin
                    m_x[g][p] = m_ops[g][0];
                    m_y[g][p] = m_ops[g][1];
                end else begin
                    m_x[g][p] = m_ops[g][2] + 32'h0001_0000;
                    m_y[g][p] = m_ops[g][3];
                end
                m_iter[g] = (m_c[g] / STEP < iters_of(g)) ? m_c[g] / STEP : iters_of(g) - 1;
                if (m_c[g] == STEP * iters_of(g)) m_done[g] = 1'b1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                for (int i = 0; i < NP; i++) begin
                    m_x[g][i] = '0;
                    m_y[g][i] = '0;
                end
                for (int j = 0; j < 6; j++) m_ops[g][j] = '0;
                m_last[g] = 1'b0;
                m_busy[g] = 1'b0;
                m_done[g] = 1'b0;
                m_c[g]    = 0;
                m_iter[g] = 0;
            end
        end else begin
            for (int g = 0; g < 2; g++) model_step(g);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        #3;
        if (chk_en) begin
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("busy[%0d]", g),      32'(busy[g]),       32'(m_busy[g]));
                chk($sformatf("done[%0d]", g),      32'(done[g]),       32'(m_done[g]));
                chk($sformatf("ld_ready[%0d]", g),  32'(ld_ready[g]),   32'(!m_busy[g]));
                chk($sformatf("iter_cnt[%0d]", g),  32'(iter_cnt[g]),   32'(m_iter[g]));
                chk($sformatf("ec_up_x[%0d]", g),   ec_up_x[g],         m_ops[g][0]);
                chk($sformatf("ec_up_y[%0d]", g),   ec_up_y[g],         m_ops[g][1]);
                chk($sformatf("ec_x[%0d]", g),      ec_x[g],            m_ops[g][2]);
                chk($sformatf("ec_y[%0d]", g),      ec_y[g],            m_ops[g][3]);
                chk($sformatf("ec_down_x[%0d]", g), ec_down_x[g],       m_ops[g][4]);
                chk($sformatf("ec_down_y[%0d]", g), ec_down_y[g],       m_ops[g][5]);
                chk($sformatf("ec_is_last[%0d]", g), 32'(ec_is_last[g]), 32'(m_last[g]));
                chk($sformatf("rd_x[%0d]", g),      rd_x[g],            m_x[g][rd_idx[g]]);
                chk($sformatf("rd_y[%0d]", g),      rd_y[g],            m_y[g][rd_idx[g]]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic        snap_last   [64];
    logic [31:0] snap_x      [64];
    logic [31:0] snap_down_x [64];

    task automatic load(input int g, input int i, input logic [31:0] x, input logic [31:0] y);
        ld_valid[g] = 1'b1;
        ld_idx[g]   = 2'(i);
        ld_x[g]     = x;
        ld_y[g]     = y;
        @(negedge clk);
        ld_valid[g] = 1'b0;
    endtask

    task automatic rd_chk(input int g, input int i, input logic [31:0] ex, input string name);
        @(negedge clk);
        rd_idx[g] = 2'(i);
        #1;
        chk(name, rd_x[g], ex);
    endtask

    // Pulse start, then count edges after the accepting edge until done.
    task automatic run_case(input int g, input int inj_at, input bit start_in_done,
                            input int abort_at, output int edges);
        bit seen;
        seen = 1'b0;
        start[g] = 1'b1;
        @(negedge clk);
        start[g]    = 1'b0;
        ld_valid[g] = 1'b0;
        edges = 0;
        while (!seen && edges < 200) begin
            @(negedge clk);
            edges++;
            ld_valid[g] = 1'b0;
            start[g]    = 1'b0;
            if (edges < 64) begin
                snap_last[edges]   = ec_is_last[g];
                snap_x[edges]      = ec_x[g];
                snap_down_x[edges] = ec_down_x[g];
            end
            if (edges == abort_at) return;
            if (edges == inj_at) begin
                ld_valid[g] = 1'b1;
                ld_idx[g]   = 2'd2;
                ld_x[g]     = 32'h7FFF_0000;
                ld_y[g]     = 32'h0000_7FFF;
                start[g]    = 1'b1;
            end
            if (done[g]) begin
                seen = 1'b1;
                if (start_in_done) start[g] = 1'b1;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL run_timeout[%0d]: got no done, required done within 200 edges", g);
        end
        @(negedge clk);
        start[g]    = 1'b0;
        ld_valid[g] = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int e;
        for (int g = 0; g < 2; g++) begin
            ld_valid[g] = 1'b0;
            ld_idx[g]   = '0;
            ld_x[g]     = '0;
            ld_y[g]     = '0;
            start[g]    = 1'b0;
            rd_idx[g]   = '0;
            stub_up[g]  = 1'b0;
        end
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        #1;
        chk("reset_busy",     32'(busy[0]),     32'd0);
        chk("reset_ld_ready", 32'(ld_ready[0]), 32'd1);
        chk("reset_done",     32'(done[0]),     32'd0);
        chk("reset_ec_x",     ec_x[0],          32'd0);
        chk("reset_rd_x",     rd_x[0],          32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Increment stub, ITERS=2
        load(0, 0, 32'h0000_0000, 32'h100);
        load(0, 1, 32'h0001_0000, 32'h101);
        load(0, 2, 32'h0002_0000, 32'h102);
        load(0, 3, 32'h0003_0000, 32'h103);
        run_case(0, -1, 1'b0, -1, e);
        chk("t1_done_edges", e, 32'd18);
        rd_chk(0, 0, 32'h0000_0000, "t1_file0");
        rd_chk(0, 1, 32'h0003_0000, "t1_file1");
        rd_chk(0, 2, 32'h0004_0000, "t1_file2");
        rd_chk(0, 3, 32'h0005_0000, "t1_file3");
        chk("t1_file3_y", rd_y[0], 32'h103);

        // Gauss-Seidel ordering and last-point handling, up-copy stub, ITERS=1
        stub_up[1] = 1'b1;
        load(1, 0, 32'h0000_0000, 32'h0);
        load(1, 1, 32'h000A_0000, 32'h0);
        load(1, 2, 32'h0014_0000, 32'h0);
        load(1, 3, 32'h001E_0000, 32'h0);
        run_case(1, -1, 1'b0, -1, e);
        chk("t2_done_edges", e, 32'd9);
        chk("t2_last_p1",    32'(snap_last[1]), 32'd0);
        chk("t2_down_p1",    snap_down_x[1],    32'h0014_0000);
        chk("t2_last_p2",    32'(snap_last[4]), 32'd0);
        chk("t2_x_p2",       snap_x[4],         32'h0014_0000);
        chk("t2_last_p3",    32'(snap_last[7]), 32'd1);
        chk("t2_down_p3",    snap_down_x[7],    32'h0);
        chk("t2_x_p3",       snap_x[7],         32'h001E_0000);
        for (int i = 0; i < NP; i++) rd_chk(1, i, 32'h0, $sformatf("t2_file%0d", i));

        // Busy rejection: load + start mid-run, start again during DONE
        run_case(0, 5, 1'b1, -1, e);
        chk("t3_done_edges", e, 32'd18);
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("t3_no_rerun", 32'(busy[0]), 32'd0);
        end
        rd_chk(0, 1, 32'h0005_0000, "t3_file1");
        rd_chk(0, 2, 32'h0006_0000, "t3_file2");
        rd_chk(0, 3, 32'h0007_0000, "t3_file3");

        // Reset during EVAL (edge 1 after accept leaves SETUP)
        run_case(0, -1, 1'b0, 1, e);
        #2 rst = 1'b1;
        #1;
        chk("t4_busy",      32'(busy[0]), 32'd0);
        chk("t4_done",      32'(done[0]), 32'd0);
        chk("t4_ec_up_x",   ec_up_x[0],   32'd0);
        chk("t4_ec_x",      ec_x[0],      32'd0);
        chk("t4_ec_y",      ec_y[0],      32'd0);
        chk("t4_ec_down_x", ec_down_x[0], 32'd0);
        chk("t4_is_last",   32'(ec_is_last[0]), 32'd0);
        for (int i = 0; i < NP; i++) begin
            rd_idx[0] = 2'(i);
            #1;
            chk($sformatf("t4_rst_x%0d", i), rd_x[0], 32'd0);
            chk($sformatf("t4_rst_y%0d", i), rd_y[0], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        load(0, 0, 32'h0000_1000, 32'h0);
        load(0, 1, 32'h0000_2000, 32'h0);
        load(0, 2, 32'h0000_3000, 32'h0);
        load(0, 3, 32'h0000_4000, 32'h0);
        run_case(0, -1, 1'b0, -1, e);
        chk("t4_done_edges", e, 32'd18);
        rd_chk(0, 0, 32'h0000_1000, "t4_file0");
        rd_chk(0, 1, 32'h0002_2000, "t4_file1");
        rd_chk(0, 3, 32'h0002_4000, "t4_file3");

        // Load and start in the same IDLE cycle, increment stub, ITERS=1
        stub_up[1]  = 1'b0;
        ld_valid[1] = 1'b1;
        ld_idx[1]   = 2'd1;
        ld_x[1]     = 32'h0005_0000;
        ld_y[1]     = 32'h0000_0007;
        run_case(1, -1, 1'b0, -1, e);
        chk("t5_done_edges", e, 32'd9);
        chk("t5_first_ec_x", snap_x[1], 32'h0005_0000);
        rd_chk(1, 1, 32'h0006_0000, "t5_file1");
        chk("t5_file1_y", rd_y[1], 32'h7);
        rd_chk(1, 2, 32'h0001_0000, "t5_file2");

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/constraint_scheduler.md
# constraint_scheduler

Sequencing controller for the combinational `enforce_constraint` datapath in the rope/chain simulator. It holds a register file of point positions, loaded over a simple write port. On `start` it runs `ITERS` Gauss-Seidel relaxation sweeps over points 1..N_POINTS-1, with point 0 pinned as the anchor. For each point it presents the up/current/down neighbours to the datapath, waits for the result to settle, and writes the corrected position back in place.

## Interface
- `N_POINTS`, default 16: number of chain points; must be ≥2.
- `ITERS`, default 4: relaxation sweeps per `start`; must be ≥1.
- `IDX_W`, default 4: index width; must satisfy 2^IDX_W ≥ N_POINTS.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ld_valid`  in  1  write `ld_x`/`ld_y` into point `ld_idx`.
- `ld_idx`  in  IDX_W  point index for the load.
- `ld_x`, `ld_y`  in  32  fixed-point position to load.
- `ld_ready`  out  1  `!busy`; loads are accepted only while high.
- `start`  in  1  begin a relaxation run; sampled in IDLE only.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE state.
- `done`  out  1  one-cycle pulse when the run completes.
- `iter_cnt`  out  IDX_W  current sweep number, 0-based.
- `rd_idx`  in  IDX_W  combinational read address.
- `rd_x`, `rd_y`  out  32  file[`rd_idx`]; returns 0 if `rd_idx` ≥ N_POINTS.
- `ec_up_x`, `ec_up_y`, `ec_x`, `ec_y`, `ec_down_x`, `ec_down_y`  out  32  registered datapath operands.
- `ec_is_last`  out  1  registered; high when the current point is N_POINTS-1.
- `ec_x_new`, `ec_y_new`  in  32  datapath result (`x_enforced_constraints`, `y_enforced_constraints`).

## Operation
- All position words are opaque 32-bit fixed-point values; the block does no arithmetic on them, only index and sweep counters.
- Load path: when `ld_valid`=1, `busy`=0 and `ld_idx` < N_POINTS, the file entry is written on the clock edge. Out-of-range indices and loads during `busy` are dropped silently.
- FSM states are IDLE, SETUP, EVAL, WRITE and DONE.
- IDLE: when `start`=1, go to SETUP with idx=1 and `iter_cnt`=0.
  - If `ld_valid` is also high in the same cycle, the load is still performed. SETUP reads the file one edge later, so it sees the loaded value.
- SETUP: register the datapath operands, then go to EVAL.
  - `ec_up` = file[idx-1].
  - `ec` = file[idx].
  - `ec_down` = file[idx+1], or file[idx-1] when idx = N_POINTS-1.
  - `ec_is_last` = (idx == N_POINTS-1).
- EVAL: one settle cycle for the divider-heavy combinational path; go to WRITE.
- WRITE: file[idx] ← (`ec_x_new`, `ec_y_new`). Next state:
  - idx < N_POINTS-1: idx++, go to SETUP.
  - idx = N_POINTS-1 and `iter_cnt` < ITERS-1: `iter_cnt`++, idx=1, go to SETUP.
  - Otherwise: go to DONE.
- Updates are in place (Gauss-Seidel): point idx+1 sees the already-updated point idx as its up neighbour.
- DONE: `done`=1 for this single cycle, then return to IDLE. `start` is ignored in DONE.
- `start` is ignored while `busy`=1.
- File entry 0 is never modified by a run.

## Timing
- Reset (asynchronous, any state):
  - state = IDLE; idx = 1; `iter_cnt` = 0.
  - Every file entry is 0.
  - All `ec_*` outputs are 0; `busy` = 0; `done` = 0; `ld_ready` = 1.
  - A run aborted by reset leaves no partial state.
- Each point takes exactly 3 cycles (SETUP, EVAL, WRITE).
- `done` is high in the cycle after the edge that is 3·(N_POINTS-1)·ITERS edges after the edge that accepted `start`.
- `busy` rises on the accepting edge and falls on the edge leaving DONE.
- `ec_*` operands change only on the edge leaving SETUP; they are stable throughout EVAL and WRITE. Between runs they hold their last values.
- `rd_x`/`rd_y` are combinational from the file. Values written in WRITE are visible on the read port the following cycle.

## Test plan
- Stub datapath returns `ec_x` + 0x00010000 and `ec_y` unchanged; N_POINTS=4, ITERS=2; load x = 0, 0x10000, 0x20000, 0x30000.
  - Required: final x = 0, 0x30000, 0x40000, 0x50000.
  - Required: `done` exactly 18 edges after `start`; `busy` high throughout.
- Gauss-Seidel ordering: stub returns `ec_up_x`; N_POINTS=4, ITERS=1; load x = 0, 0xA0000, 0x140000, 0x1E0000.
  - Required: all entries read 0 after `done`.
- Last-point handling: same stub as the previous case; observe the idx=3 SETUP.
  - Required: `ec_is_last`=1, and `ec_down_x` equals the post-update value of point 2.
  - Required: `ec_is_last`=0 for idx 1 and 2.
- Busy rejection: during a run, assert `ld_valid` with `ld_idx`=2, `ld_x`=0x7FFF0000, and pulse `start`.
  - Required: file entry 2 is unaffected by the load and no second run occurs.
  - Required: `ld_ready`=0 throughout the run.
- Reset mid-run: assert `rst` during an EVAL cycle.
  - Required: immediately `busy`=0, `done`=0, all `ec_*`=0, and every `rd_x`/`rd_y` = 0.
  - Required: a subsequent load plus `start` completes with correct timing.
- Simultaneous `ld_valid` (`ld_idx`=1, `ld_x`=0x50000) and `start` in IDLE, with the increment stub and ITERS=1.
  - Required: first-cycle `ec_x`=0x50000 and final file[1] = 0x60000.
